// File: rtl/id_decode_sb.sv
// Instruction-decode stage with register file, per-register RAW scoreboard and
// stall/bubble generation. Optional macro ID_WB_BYPASS_EN forwards write-back data.
module id_decode_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 16,
   parameter int AW   = 4,
   parameter int P_RD = 20,
   parameter int P_RS = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   input  logic [31:0]     inst_i,
   output logic            stall_o,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic            wb_i,
   input  logic [AW-1:0]   wb_r_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic            valid_o,
   output logic            ctrl_inte_o,
   output logic            ctrl_logic_o,
   output logic            ctrl_shift_o,
   output logic            ctrl_ld_o,
   output logic            ctrl_st_o,
   output logic            ctrl_br_o,
   output logic            illegal_o,
   output logic            immf_o,
   output logic [XLEN-1:0] imm_value_o,
   output logic [AW-1:0]   rd_addr_o,
   output logic [XLEN-1:0] rd_value_o,
   output logic [XLEN-1:0] rs_value_o
);

   // decode vector layout: {inte, logic, shift, ld, st, br, imm16, rsv, und}
   function automatic logic [8:0] decode(input logic [6:0] opc);
      logic [8:0] d;
      case (opc)
         7'h00, 7'h01, 7'h02, 7'h03,
         7'h05, 7'h06, 7'h07:                 d = 9'b100000010;
         7'h04:                               d = 9'b100000000;
         7'h08, 7'h09, 7'h0A, 7'h0C, 7'h0D:   d = 9'b001000110;
         7'h10, 7'h11, 7'h12, 7'h13:          d = 9'b010000010;
         7'h16, 7'h17:                        d = 9'b000000010;
         7'h18:                               d = 9'b000100010;
         7'h19:                               d = 9'b000010010;
         7'h1C, 7'h1D, 7'h1E, 7'h1F:          d = 9'b000001010;
         default:                             d = 9'b000000001;
      endcase
      return d;
   endfunction

   function automatic logic [XLEN-1:0] ext_imm(input logic [15:0] imm, input logic zext);
      logic signed [15:0]     s16;
      logic signed [XLEN-1:0] sx;
      s16 = imm;
      sx  = s16;
      return zext ? XLEN'(imm) : sx;
   endfunction

   logic [6:0]      opc_p0;
   logic            immf_p0;
   logic [AW-1:0]   rd_p0, rs_p0;
   logic [15:0]     imm_p0;
   logic [8:0]      dec_p0;
   logic [XLEN-1:0] rd_val_p0, rs_val_p0;
   logic            hazard_p0, issue_p0;

   logic [XLEN-1:0] rf [NREG];
   logic [NREG-1:0] sb, sb_eff;

   assign opc_p0  = inst_i[31:25];
   assign immf_p0 = inst_i[24];
   assign rd_p0   = inst_i[P_RD +: AW];
   assign rs_p0   = inst_i[P_RS +: AW];
   assign imm_p0  = inst_i[15:0];
   assign dec_p0  = decode(opc_p0);

`ifdef ID_WB_BYPASS_EN
   // A same-cycle write-back both supplies the operand and resolves the reservation.
   always_comb begin
      sb_eff = sb;
      if (wb_i) sb_eff[wb_r_i] = 1'b0;
      rd_val_p0 = (wb_i && wb_r_i == rd_p0) ? wb_data_i : rf[rd_p0];
      rs_val_p0 = (wb_i && wb_r_i == rs_p0) ? wb_data_i : rf[rs_p0];
   end
`else
   assign sb_eff    = sb;
   assign rd_val_p0 = rf[rd_p0];
   assign rs_val_p0 = rf[rs_p0];
`endif

   assign hazard_p0 = valid_i & ~dec_p0[0] & (sb_eff[rd_p0] | (sb_eff[rs_p0] & ~immf_p0));
   assign stall_o   = valid_i & (hazard_p0 | stall_i) & ~flush_i;
   assign issue_p0  = valid_i & ~hazard_p0 & ~stall_i & ~flush_i;

   // ---- stage boundary: decode -> execute output register ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_o      <= 1'b0;
         {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o} <= '0;
         illegal_o    <= 1'b0;
         immf_o       <= 1'b0;
         imm_value_o  <= '0;
         rd_addr_o    <= '0;
         rd_value_o   <= '0;
         rs_value_o   <= '0;
      end else if (flush_i) begin
         valid_o   <= 1'b0;
         {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o} <= '0;
         illegal_o <= 1'b0;
      end else if (!stall_i) begin
         if (issue_p0) begin
            valid_o     <= 1'b1;
            {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o} <= dec_p0[8:3];
            illegal_o   <= dec_p0[0];
            immf_o      <= immf_p0;
            imm_value_o <= ext_imm(imm_p0, dec_p0[2]);
            rd_addr_o   <= rd_p0;
            rd_value_o  <= rd_val_p0;
            rs_value_o  <= rs_val_p0;
         end else begin
            valid_o   <= 1'b0;
            {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o} <= '0;
            illegal_o <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wb_i) begin
         rf[wb_r_i] <= wb_data_i;
      end
   end

   // A reservation made this cycle overrides a write-back clearing the same entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sb <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (issue_p0 && dec_p0[1] && rd_p0 == AW'(i))
               sb[i] <= 1'b1;
            else if (wb_i && wb_r_i == AW'(i))
               sb[i] <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_id_decode_sb.sv
// Self-checking bench for id_decode_sb: directed steps followed by random
// traffic, compared against a behavioural reference model.
module tb_id_decode_sb;
   localparam int XLEN = 32;
   localparam int NREG = 16;
   localparam int AW   = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            valid_i, stall_i, flush_i, wb_i;
   logic [31:0]     inst_i;
   logic [AW-1:0]   wb_r_i;
   logic [XLEN-1:0] wb_data_i;
   logic            stall_o, valid_o, illegal_o, immf_o;
   logic            ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o;
   logic [XLEN-1:0] imm_value_o, rd_value_o, rs_value_o;
   logic [AW-1:0]   rd_addr_o;

   id_decode_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .P_RD(20), .P_RS(16)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .inst_i(inst_i), .stall_o(stall_o),
      .stall_i(stall_i), .flush_i(flush_i), .wb_i(wb_i), .wb_r_i(wb_r_i),
      .wb_data_i(wb_data_i), .valid_o(valid_o), .ctrl_inte_o(ctrl_inte_o),
      .ctrl_logic_o(ctrl_logic_o), .ctrl_shift_o(ctrl_shift_o), .ctrl_ld_o(ctrl_ld_o),
      .ctrl_st_o(ctrl_st_o), .ctrl_br_o(ctrl_br_o), .illegal_o(illegal_o),
      .immf_o(immf_o), .imm_value_o(imm_value_o), .rd_addr_o(rd_addr_o),
      .rd_value_o(rd_value_o), .rs_value_o(rs_value_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] m_rf [NREG];
   logic [NREG-1:0] m_sb;
   logic            m_valid, m_ill, m_ill_known, m_immf;
   logic [5:0]      m_ctrl;
   logic [XLEN-1:0] m_imm, m_rdv, m_rsv;
   logic [AW-1:0]   m_rd;

`ifdef ID_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] op, input logic imf,
                                      input logic [3:0] rd, input logic [3:0] rs,
                                      input logic [15:0] imm);
      return {op, imf, rd, rs, imm};
   endfunction

   // Opcode table from its range rules: {inte, logic, shift, ld, st, br, imm16, rsv, und}
   function automatic logic [8:0] ref_dec(input int op);
      logic inte, lg, sh, ld, st, br, i16, rsv, und;
      inte = (op <= 7);
      sh   = (op == 8 || op == 9 || op == 10 || op == 12 || op == 13);
      lg   = (op >= 16 && op <= 19);
      ld   = (op == 24);
      st   = (op == 25);
      br   = (op >= 28 && op <= 31);
      i16  = sh;
      und  = !(inte || sh || lg || ld || st || br || op == 22 || op == 23);
      rsv  = !und && (op != 4);
      return {inte, lg, sh, ld, st, br, i16, rsv, und};
   endfunction

   task automatic compare_outputs();
      chk("valid_o", valid_o, m_valid);
      chk("ctrl", {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o}, m_ctrl);
      if (m_ill_known) chk("illegal_o", illegal_o, m_ill);
      if (m_valid) begin
         chk("immf_o", immf_o, m_immf);
         chk("imm_value_o", imm_value_o, m_imm);
         chk("rd_addr_o", rd_addr_o, m_rd);
         chk("rd_value_o", rd_value_o, m_rdv);
         chk("rs_value_o", rs_value_o, m_rsv);
      end
      chk("scoreboard", dut.sb, m_sb);
   endtask

   task automatic cycle(input logic v, input logic [31:0] ins, input logic si, input logic fl,
                        input logic w, input logic [AW-1:0] wr, input logic [XLEN-1:0] wd);
      logic [8:0]    d;
      logic [AW-1:0] ra, sa;
      logic          hit_rd, hit_rs, haz, iss;
      valid_i = v; inst_i = ins; stall_i = si; flush_i = fl;
      wb_i = w; wb_r_i = wr; wb_data_i = wd;
      #1;
      d      = ref_dec(int'(ins[31:25]));
      ra     = ins[23:20];
      sa     = ins[19:16];
      hit_rd = BYP && w && (wr == ra);
      hit_rs = BYP && w && (wr == sa);
      haz    = v && !d[0] && ((m_sb[ra] && !hit_rd) || (m_sb[sa] && !hit_rs && !ins[24]));
      chk("stall_o", stall_o, v && (haz || si) && !fl);
      iss = v && !haz && !si && !fl;
      if (fl) begin
         m_valid = 0; m_ctrl = 0; m_ill_known = 0;
      end else if (!si) begin
         if (iss) begin
            m_valid = 1; m_ctrl = d[8:3]; m_ill = d[0]; m_ill_known = 1;
            m_immf  = ins[24];
            m_imm   = d[2] ? {16'h0, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
            m_rd    = ra;
            m_rdv   = hit_rd ? wd : m_rf[ra];
            m_rsv   = hit_rs ? wd : m_rf[sa];
         end else begin
            m_valid = 0; m_ctrl = 0; m_ill = 0; m_ill_known = 1;
         end
      end
      if (w) m_sb[wr] = 1'b0;
      if (iss && d[1]) m_sb[ra] = 1'b1;
      if (w) m_rf[wr] = wd;
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic idle_wb(input logic [AW-1:0] r, input logic [XLEN-1:0] v);
      cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, r, v);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) m_rf[i] = '0;
      m_sb = '0; m_valid = 0; m_ctrl = 0; m_ill = 0; m_ill_known = 1;
      m_immf = 0; m_imm = '0; m_rd = '0; m_rdv = '0; m_rsv = '0;
   endtask

   logic [6:0] legal_ops [25] = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07,
                                  7'h08, 7'h09, 7'h0A, 7'h0C, 7'h0D, 7'h10, 7'h11, 7'h12,
                                  7'h13, 7'h16, 7'h17, 7'h18, 7'h19, 7'h1C, 7'h1D, 7'h1E, 7'h1F};

   initial begin
      logic [31:0] ins;
      logic [6:0]  op;
      rst = 1'b0; valid_i = 0; inst_i = '0; stall_i = 0; flush_i = 0;
      wb_i = 0; wb_r_i = '0; wb_data_i = '0;
      model_reset();
      #12 rst = 1'b1;

      // Stream some state in, then reset mid-stream
      idle_wb(4'd4, 32'hDEAD_BEEF);
      cycle(1, mk(7'h00, 0, 4'd9, 4'd4, 16'h0001), 0, 0, 0, 0, 0);
      chk("pre_reset_valid", valid_o, 1'b1);
      valid_i = 1; inst_i = mk(7'h10, 0, 4'd9, 4'd9, 16'h0); stall_i = 0; flush_i = 0; wb_i = 0;
      rst = 1'b0;
      #2;
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_ctrl", {ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o}, 6'h0);
      chk("rst_illegal", illegal_o, 1'b0);
      chk("rst_imm", imm_value_o, 32'h0);
      chk("rst_data", {rd_value_o, rs_value_o}, 64'h0);
      chk("rst_rd_addr", rd_addr_o, 4'h0);
      chk("rst_sb", dut.sb, 16'h0);
      chk("rst_stall_o", stall_o, 1'b0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b1;

      // Step 1: first issue after reset reads the cleared register file
      cycle(1, mk(7'h00, 0, 4'd3, 4'd4, 16'h0), 0, 0, 0, 0, 0);
      chk("t1_valid", valid_o, 1'b1);
      chk("t1_inte", ctrl_inte_o, 1'b1);
      chk("t1_rs_value", rs_value_o, 32'h0);
      chk("t1_sb3", dut.sb[3], 1'b1);

      // Step 2: RAW on r3 stalls until write-back
      cycle(1, mk(7'h10, 0, 4'd5, 4'd3, 16'h0), 0, 0, 0, 0, 0);
      chk("t2_bubble", valid_o, 1'b0);
      cycle(1, mk(7'h10, 0, 4'd5, 4'd3, 16'h0), 0, 0, 1, 4'd3, 32'h1234);
`ifdef ID_WB_BYPASS_EN
      chk("t2_byp_valid", valid_o, 1'b1);
      chk("t2_byp_rs", rs_value_o, 32'h1234);
`else
      chk("t2_wait_valid", valid_o, 1'b0);
      cycle(1, mk(7'h10, 0, 4'd5, 4'd3, 16'h0), 0, 0, 0, 0, 0);
      chk("t2_valid", valid_o, 1'b1);
      chk("t2_rs", rs_value_o, 32'h1234);
`endif
      idle_wb(4'd5, 32'h5555);

      // Step 3: immediate extension
      cycle(1, mk(7'h08, 0, 4'd1, 4'd2, 16'h8000), 0, 0, 0, 0, 0);
      chk("t3_zext", imm_value_o, 32'h0000_8000);
      cycle(1, mk(7'h00, 0, 4'd2, 4'd0, 16'h8000), 0, 0, 0, 0, 0);
      chk("t3_sext", imm_value_o, 32'hFFFF_8000);
      idle_wb(4'd1, 32'h1111);
      idle_wb(4'd2, 32'h2222);

      // Step 4: downstream stall holds, flush discards
      cycle(1, mk(7'h11, 1, 4'd8, 4'd0, 16'h00AA), 0, 0, 0, 0, 0);
      cycle(1, mk(7'h00, 0, 4'd10, 4'd1, 16'h0), 1, 0, 0, 0, 0);
      chk("t4_hold_valid", valid_o, 1'b1);
      chk("t4_hold_rd", rd_addr_o, 4'd8);
      cycle(1, mk(7'h00, 0, 4'd10, 4'd1, 16'h0), 1, 1, 0, 0, 0);
      chk("t4_flush_valid", valid_o, 1'b0);
      cycle(1, mk(7'h00, 0, 4'd10, 4'd1, 16'h0), 1, 0, 0, 0, 0);
      chk("t4_after_flush", valid_o, 1'b0);
      chk("t4_sb10", dut.sb[10], 1'b0);
      idle_wb(4'd8, 32'h8888);

      // Step 5: undefined opcode and non-reserving 0x04
      cycle(1, mk(7'h7F, 0, 4'd11, 4'd0, 16'h0), 0, 0, 0, 0, 0);
      chk("t5_illegal", illegal_o, 1'b1);
      chk("t5_sb11", dut.sb[11], 1'b0);
      cycle(1, mk(7'h04, 0, 4'd6, 4'd0, 16'h0), 0, 0, 0, 0, 0);
      chk("t5_sb6", dut.sb[6], 1'b0);

      // Step 6: reservation beats same-cycle write-back clear
      cycle(1, mk(7'h00, 0, 4'd7, 4'd0, 16'h0), 0, 0, 1, 4'd7, 32'h77);
      chk("t6_sb7", dut.sb[7], 1'b1);
      idle_wb(4'd7, 32'h7777);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         op  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                           : legal_ops[$urandom_range(0, 24)];
         ins = {op, 1'($urandom), 4'($urandom), 4'($urandom), 16'($urandom)};
         cycle(1'($urandom_range(0, 9) < 8), ins,
               1'($urandom_range(0, 99) < 15), 1'($urandom_range(0, 99) < 5),
               1'($urandom_range(0, 1)), 4'($urandom), 32'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/id_decode_sb.md
Name: id_decode_sb

Overview:
- Parametrised next-generation instruction-decode stage.
- Decodes the 7-bit opcode into class controls, reads a NREG x XLEN register file and extends the 16-bit immediate to XLEN.
- Tracks in-flight destination registers in a per-register scoreboard, generates the RAW-hazard stall itself and inserts bubbles.
- Sits between fetch and execute: valid/stall handshake upstream, valid/stall/flush downstream, write-back port from WB.

Parameters:
- XLEN, 32, data and register width (must be >= 16).
- NREG, 16, number of architectural registers (power of 2, <= 16).
- AW, 4, register address width; log2(NREG).
- P_RD, 20, LSB position of rd field in inst_i.
- P_RS, 16, LSB position of rs field in inst_i.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- valid_i  in  1  inst_i holds a valid instruction.
- inst_i  in  32  instruction: [31:25] opcode, [24] immf, rd/rs at P_RD/P_RS, [15:0] imm.
- stall_o  out  1  upstream must hold inst_i this cycle (combinational).
- stall_i  in  1  downstream stalled; hold all outputs.
- flush_i  in  1  discard the instruction being decoded.
- wb_i  in  1  write-back enable.
- wb_r_i  in  AW  write-back register address.
- wb_data_i  in  XLEN  write-back data.
- valid_o  out  1  outputs hold a decoded instruction.
- ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o  out  1 each  class controls.
- illegal_o  out  1  undefined opcode issued.
- immf_o  out  1  copy of inst_i[24].
- imm_value_o  out  XLEN  extended immediate.
- rd_addr_o  out  AW  destination register address.
- rd_value_o, rs_value_o  out  XLEN  registered operand values.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, all regfile entries 0, all scoreboard bits 0. Reset mid-stall discards everything.
- Opcode table decodes each opcode to {inte, logic, shift, ld, st, br, imm16, rsv, und}:
  - 0x00-0x07: inte; rsv=1, except 0x04 which has rsv=0.
  - 0x08, 0x09, 0x0A, 0x0C, 0x0D: shift, imm16=1, rsv=1.
  - 0x10-0x13: logic, rsv=1.
  - 0x16, 0x17: no class bit, rsv=1.
  - 0x18: ld, rsv=1.
  - 0x19: st, rsv=1.
  - 0x1C-0x1F: br, rsv=1.
  - Any other opcode: und=1, all other bits 0.
- Immediate extension: imm16=0 sign-extends inst_i[15:0] to XLEN; imm16=1 zero-extends it.
- Hazard = valid_i & ~und & (sb[rd] | (sb[rs] & ~inst_i[24])). The rs check is skipped when immf=1.
- stall_o = valid_i & (hazard | stall_i) & ~flush_i.
- issue = valid_i & ~hazard & ~stall_i & ~flush_i.
- Output pipeline register, in priority order:
  - flush_i → valid_o=0, controls=0.
  - else stall_i → hold every output.
  - else issue → load all fields, valid_o=1.
  - else → bubble: valid_o=0, controls and illegal_o=0, data fields don't-care.
- Latency: 1 cycle from issue to valid_o.
- Register file:
  - Write on posedge when wb_i.
  - Reads are combinational and captured at issue.
- Scoreboard:
  - Set sb[rd] on issue when rsv=1.
  - Clear sb[wb_r_i] on wb_i.
  - Same register set and cleared in one cycle: set wins.
- Undefined opcode: issues with illegal_o=1 and all controls 0, never reserves.
- flush_i does not clear the scoreboard; in-flight instructions still write back.

Optional Feature:
- Macro: ID_WB_BYPASS_EN.
- Defined: when wb_i=1 and wb_r_i matches rd or rs, the read value is wb_data_i and that register's scoreboard bit is treated as 0 for the hazard check. An instruction waiting on WB issues in the same cycle as the write-back.
- Undefined: regfile and scoreboard update only at the edge, so a dependent instruction issues one cycle after write-back and reads the stored value.

Test Plan:
1. Reset with rst=0 mid-stream → all outputs 0, sb all 0. After release, opcode 0x00 rd=3 rs=4 with r4=0 → valid_o=1, ctrl_inte_o=1, rs_value_o=0, sb[3]=1.
2. Issue 0x00 rd=3, then 0x10 rd=5 rs=3 immf=0 → stall_o=1, bubble with valid_o=0. Then wb_i=1, wb_r_i=3, wb_data_i=0x1234 → issue with rs_value_o=0x1234: same cycle with ID_WB_BYPASS_EN, next cycle without.
3. Shift opcode 0x08 with imm=0x8000 → imm_value_o=0x00008000. Opcode 0x00 with imm=0x8000 → imm_value_o=0xFFFF8000.
4. stall_i=1 for 3 cycles while valid_o=1 → all outputs held and stall_o=1. With flush_i=1 on the 2nd cycle → valid_o=0 next cycle and the held instruction is discarded.
5. Opcode 0x7F → illegal_o=1, controls 0, no scoreboard bit set. Opcode 0x04 rd=6 → sb[6] stays 0.
6. wb_i to r7 in the same cycle as issuing 0x00 rd=7 → sb[7]=1 afterwards (set wins).
